// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state type and default sizing for the round-robin memory arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester/arbiter handshake bundle; master = requesters, slave = arbiter
interface mem_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [W-1:0]       gnt_id;
  logic               busy;
  logic               timeout_err;
  modport master (output req, done, input grant, gnt_id, busy, timeout_err);
  modport slave  (input req, done, output grant, gnt_id, busy, timeout_err);
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set req bit at or above ptr with wrap
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  int j;
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // scan from the farthest offset down so the nearest hit to ptr is the last write
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = (j >= N) ? j - N : j;
      if (req[W'(j)]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with IDLE/GRANT/RELEASE FSM and registered one-hot grant.
// Define ARB_TIMEOUT_EN to add a hold counter that forces release after MAX_HOLD grant cycles.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = DEF_NUM_REQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int W        = $clog2(NUM_REQ)
) (
  input logic         Clock,
  input logic         Reset,
  mem_arbiter_if.slave bus
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("mem_arbiter: NUM_REQ must be 2..8 and MAX_HOLD 1..255");
  end
  arb_state_t         state;
  logic [W-1:0]       rr_ptr;
  logic [W-1:0]       pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] grant_q;
  logic [W-1:0]       gnt_q;
  logic               busy_q;
  logic               to_hit;
  logic               rel;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       terr;
  assign to_hit          = hold_cnt == 8'(MAX_HOLD);
  assign bus.timeout_err = terr;
  always_ff @(posedge Clock)
    if (Reset) begin
      hold_cnt <= '0;
      terr     <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? (rel ? '0 : hold_cnt + 8'd1) : (pick_valid ? 8'd1 : '0);
      terr     <= state == GRANT && to_hit && !bus.done[gnt_q];
    end
`else
  assign to_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign rel        = bus.done[gnt_q] | ~bus.req[gnt_q] | to_hit;
  assign bus.grant  = grant_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = busy_q;
  always_ff @(posedge Clock)
    if (Reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          state   <= pick_valid ? GRANT : IDLE;
          grant_q <= pick_valid ? NUM_REQ'(1) << pick_idx : '0;
          gnt_q   <= pick_valid ? pick_idx : '0;
          busy_q  <= pick_valid;
        end
        GRANT:
          if (rel) begin
            state   <= RELEASE;
            grant_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= (gnt_q == W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 8: maximum grant length in cycles (1..255); used only with ARB_TIMEOUT_EN.
REQ-003 Port Clock  input  1: the single clock; all logic SHALL update on its rising edge.
REQ-004 Port Reset  input  1: reset is synchronous and active-high.
REQ-005 Port req  input  NUM_REQ: per-requester request, level, held until granted.
REQ-006 Port done  input  NUM_REQ: per-requester release pulse; only the granted bit is honoured.
REQ-007 Port grant  output  NUM_REQ: registered one-hot grant; all-zero when no grant is active.
REQ-008 Port gnt_id  output  $clog2(NUM_REQ): binary index of the granted requester; 0 when grant is zero.
REQ-009 Port busy  output  1: high exactly when grant is non-zero.
REQ-010 Port timeout_err  output  1: one-cycle pulse on a forced release.

Function
REQ-011 States SHALL be IDLE, GRANT and RELEASE.
REQ-012 IDLE: grant zero; if any req bit is high, winner = first set bit scanning upward from rr_ptr with wrap; go to GRANT; grant and gnt_id reflect the winner in the next cycle.
REQ-013 Latency: req sampled high in cycle n with the arbiter in IDLE -> grant high in cycle n+1.
REQ-014 GRANT: grant and gnt_id SHALL stay constant; other requests are ignored.
REQ-015 GRANT exits to RELEASE when done[gnt_id] is high, or req[gnt_id] is low (abandon), or a timeout occurs (REQ-022).
REQ-016 On entry to RELEASE: rr_ptr = (gnt_id+1) mod NUM_REQ; grant is zero for the whole RELEASE cycle.
REQ-017 RELEASE: arbitration SHALL use the updated rr_ptr; any req -> GRANT next cycle, else IDLE. Back-to-back grants therefore have exactly one idle cycle between them.
REQ-018 done bits of non-granted requesters SHALL have no effect in any state.
REQ-019 A requester that is granted and still requesting after RELEASE has the lowest priority in the next arbitration.
REQ-020 With all req bits high continuously, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0.

Reset
REQ-021 While Reset is high at a rising edge: state=IDLE, rr_ptr=0, hold counter=0, grant=0, gnt_id=0, busy=0, timeout_err=0. This applies in any state, including mid-GRANT; the grant drops in the cycle after the edge.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined:
- hold counter = 1 on the first GRANT cycle, +1 per GRANT cycle.
- count == MAX_HOLD with done[gnt_id] low -> forced exit to RELEASE.
- timeout_err is high during that RELEASE cycle.
REQ-023 done[gnt_id] and timeout in the same cycle SHALL count as a normal release; timeout_err stays low.
REQ-024 Macro ARB_TIMEOUT_EN undefined: no hold counter; the grant is held until done or abandon; timeout_err is tied 0; the port list is unchanged.

Structure
REQ-025 Package arb_pkg SHALL hold the state enum arb_state_t and the default constants for NUM_REQ and MAX_HOLD.
REQ-026 Sub-module rr_pick SHALL be a combinational rotating-priority picker with inputs req and ptr, outputs valid and idx; it is instantiated once.

Verification
REQ-027 Reset, then req=4'b0100 -> grant=4'b0100 and gnt_id=2 one cycle later; done[2] pulse -> grant=0 next cycle, rr_ptr=3.
REQ-028 req=4'b1111 held, done pulsed on each grant -> grant order 0,1,2,3,0, one zero cycle between consecutive grants.
REQ-029 Granted requester 1, done[0] and done[3] pulsed -> grant stays 4'b0010.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=8, req[0] held, done never -> grant for 8 cycles, then one zero cycle with timeout_err=1, then requester 0 is re-granted only if no other request is pending.
REQ-031 ARB_TIMEOUT_EN, done[gnt_id] asserted in hold cycle 8 -> normal release, timeout_err=0.
REQ-032 Reset asserted in the third cycle of a grant -> grant=0, busy=0 next cycle; req=4'b1000 then -> grant to 3 (rr_ptr=0 scan).
